// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles every signal exchanged between the pipeline sequencer and the rest
// of the core. The clock and reset are not part of the bundle.
//
//   stallreq_*_i   per-stage stall requests (fetch, decode, execute, memory)
//   excp_*_i       committed exception/interrupt request, cause and faulting PC
//   mret_i         mret reached MEM
//   mtvec_i/mepc_i current trap vector and saved exception PC
//   stall_o        per-register hold vector (bit0 pc ... bit5 wb)
//   flush_o        bubble if/id, id/ex, ex/mem; new_pc_o is the redirect target
//   csr_*_o        controller-owned CSR write port
//   busy_o         trap sequence in progress
//   timeout_o      sticky stall watchdog flag
//
// The master modport is the sequencer; the slave modport is the core side.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;
   logic        stallreq_if_i;
   logic        stallreq_id_i;
   logic        stallreq_ex_i;
   logic        stallreq_mem_i;
   logic        excp_req_i;
   logic [31:0] excp_cause_i;
   logic [31:0] excp_pc_i;
   logic        mret_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic        busy_o;
   logic        timeout_o;

   modport master (
      input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      input  excp_req_i, excp_cause_i, excp_pc_i, mret_i, mtvec_i, mepc_i,
      output stall_o, flush_o, new_pc_o, csr_we_o, csr_waddr_o, csr_wdata_o,
      output busy_o, timeout_o
   );

   modport slave (
      output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
      output excp_req_i, excp_cause_i, excp_pc_i, mret_i, mtvec_i, mepc_i,
      input  stall_o, flush_o, new_pc_o, csr_we_o, csr_waddr_o, csr_wdata_o,
      input  busy_o, timeout_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer for the 5-stage pipeline. Merges stage stall requests
// into a hold vector, runs the trap-entry sequence (save mepc, save mcause,
// jump to mtvec), redirects fetch on mret and watches for a pipeline that
// stays frozen too long.
//
// Ports:
//   clk_i  clock, all state changes on the rising edge
//   rst_i  synchronous active-high reset
//   bus    pipe_ctrl_if.master, see the interface file for the signal list
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int          STALL_TIMEOUT = 1023,
   parameter int          CNT_WIDTH     = 10,
   parameter logic [11:0] MEPC_ADDR     = 12'h341,
   parameter logic [11:0] MCAUSE_ADDR   = 12'h342
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pipe_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      TRAP_MEPC,
      TRAP_MCAUSE,
      TRAP_JUMP
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STALL_TIMEOUT);

   state_t               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [31:0]          cause_q, cause_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
   logic                 csr_we_q, csr_we_d;
   logic [11:0]          csr_waddr_q, csr_waddr_d;
   logic [31:0]          csr_wdata_q, csr_wdata_d;
   logic                 busy_q, busy_d;

   logic [5:0]           stall_req_vec;
   logic [5:0]           stall;
   logic                 flush;
   logic [31:0]          new_pc;
   logic                 take_excp;
   logic                 take_mret;

   // Merge the stage requests: the oldest stalled stage decides, and every
   // younger register is held along with it.
   always_comb begin
      stall_req_vec = 6'b000000;
      if (bus.stallreq_mem_i) begin
         stall_req_vec = 6'b011111;
      end else if (bus.stallreq_ex_i) begin
         stall_req_vec = 6'b001111;
      end else if (bus.stallreq_id_i) begin
         stall_req_vec = 6'b000111;
      end else if (bus.stallreq_if_i) begin
         stall_req_vec = 6'b000011;
      end
   end

   // Trap/mret sequencing. Exceptions and mret are only accepted once the
   // memory stage is not waiting, so the faulting instruction is settled.
   // An exception wins over an mret arriving in the same cycle.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cause_d   = cause_q;
      stall     = 6'b000000;
      flush     = 1'b0;
      new_pc    = 32'h0;
      take_excp = 1'b0;
      take_mret = 1'b0;
      case (state_q)
         IDLE: begin
            take_excp = bus.excp_req_i && !bus.stallreq_mem_i;
            take_mret = !take_excp && bus.mret_i && !bus.stallreq_mem_i;
            stall     = take_mret ? 6'b000000 : stall_req_vec;
            if (take_mret) begin
               flush  = 1'b1;
               new_pc = bus.mepc_i;
            end
            if (take_excp) begin
               pc_d    = bus.excp_pc_i;
               cause_d = bus.excp_cause_i;
               state_d = TRAP_MEPC;
            end
         end
         TRAP_MEPC: begin
            stall   = 6'b111111;
            state_d = TRAP_MCAUSE;
         end
         TRAP_MCAUSE: begin
            stall   = 6'b111111;
            state_d = TRAP_JUMP;
         end
         TRAP_JUMP: begin
            flush   = 1'b1;
            new_pc  = bus.mtvec_i & 32'hFFFF_FFFC;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Watchdog: counts consecutive stalled cycles spent in IDLE, saturating at
   // the timeout. The flag is sticky so software can see a past freeze.
   always_comb begin
      cnt_d = '0;
      if (state_q == IDLE && state_d == IDLE && stall != 6'b000000) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      timeout_d = timeout_q | (cnt_d == CNT_MAX);
   end

   // CSR port and busy are decoded from the next state so they come straight
   // out of flops and line up with the trap state they belong to.
   always_comb begin
      csr_we_d    = 1'b0;
      csr_waddr_d = 12'h000;
      csr_wdata_d = 32'h0;
      busy_d      = (state_d != IDLE);
      case (state_d)
         TRAP_MEPC: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = MEPC_ADDR;
            csr_wdata_d = pc_d;
         end
         TRAP_MCAUSE: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = MCAUSE_ADDR;
            csr_wdata_d = cause_d;
         end
         default: begin
            csr_we_d = 1'b0;
         end
      endcase
   end

   // All state, with a synchronous reset that also abandons any trap in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         pc_q        <= 32'h0;
         cause_q     <= 32'h0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
         csr_we_q    <= 1'b0;
         csr_waddr_q <= 12'h000;
         csr_wdata_q <= 32'h0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cause_q     <= cause_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
         csr_we_q    <= csr_we_d;
         csr_waddr_q <= csr_waddr_d;
         csr_wdata_q <= csr_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.stall_o     = stall;
   assign bus.flush_o     = flush;
   assign bus.new_pc_o    = new_pc;
   assign bus.csr_we_o    = csr_we_q;
   assign bus.csr_waddr_o = csr_waddr_q;
   assign bus.csr_wdata_o = csr_wdata_q;
   assign bus.busy_o      = busy_q;
   assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Testbench for pipe_ctrl. A driver applies one cycle of inputs at a time,
// predicts that cycle's outputs from a schedule-based reference model and
// queues the prediction; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int TIMEOUT = 1023;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        csr_we;
      logic [11:0] csr_addr;
      logic [31:0] csr_data;
      logic        busy;
      logic        timeout;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i;

   pipe_ctrl_if bus ();

   pipe_ctrl #(
      .STALL_TIMEOUT (TIMEOUT),
      .CNT_WIDTH     (10),
      .MEPC_ADDR     (12'h341),
      .MCAUSE_ADDR   (12'h342)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;

   // Reference model: a trap is a queue of three scheduled cycles
   // (1 = save pc, 2 = save cause, 3 = jump); the watchdog is a plain counter.
   int          plan_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_cause;
   int          m_count   = 0;
   bit          m_timeout = 1'b0;

   // One comparison of one output field.
   task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   task automatic check_output(input exp_t e);
      check_field("stall_o",     {26'h0, bus.stall_o},     {26'h0, e.stall});
      check_field("flush_o",     {31'h0, bus.flush_o},     {31'h0, e.flush});
      check_field("new_pc_o",    bus.new_pc_o,             e.new_pc);
      check_field("csr_we_o",    {31'h0, bus.csr_we_o},    {31'h0, e.csr_we});
      check_field("csr_waddr_o", {20'h0, bus.csr_waddr_o}, {20'h0, e.csr_addr});
      check_field("csr_wdata_o", bus.csr_wdata_o,          e.csr_data);
      check_field("busy_o",      {31'h0, bus.busy_o},      {31'h0, e.busy});
      check_field("timeout_o",   {31'h0, bus.timeout_o},   {31'h0, e.timeout});
   endtask

   // Predict the current cycle, queue it, then advance the model across the
   // next rising edge using the same inputs the DUT samples.
   task automatic apply_stimulus();
      exp_t       e;
      logic [5:0] vec;
      bit         take_excp;
      bit         take_mret;
      take_excp = 1'b0;
      take_mret = 1'b0;
      if (bus.stallreq_mem_i)     vec = 6'b011111;
      else if (bus.stallreq_ex_i) vec = 6'b001111;
      else if (bus.stallreq_id_i) vec = 6'b000111;
      else if (bus.stallreq_if_i) vec = 6'b000011;
      else                        vec = 6'b000000;
      e = '{default: '0};
      e.timeout = m_timeout;
      if (plan_q.size() > 0) begin
         e.busy = 1'b1;
         if (plan_q[0] == 1) begin
            e.stall = 6'b111111; e.csr_we = 1'b1; e.csr_addr = 12'h341; e.csr_data = m_pc;
         end else if (plan_q[0] == 2) begin
            e.stall = 6'b111111; e.csr_we = 1'b1; e.csr_addr = 12'h342; e.csr_data = m_cause;
         end else begin
            e.flush = 1'b1; e.new_pc = {bus.mtvec_i[31:2], 2'b00};
         end
      end else begin
         take_excp = bus.excp_req_i && !bus.stallreq_mem_i;
         take_mret = !take_excp && bus.mret_i && !bus.stallreq_mem_i;
         e.stall   = take_mret ? 6'b000000 : vec;
         e.flush   = take_mret;
         e.new_pc  = take_mret ? bus.mepc_i : 32'h0;
      end
      exp_q.push_back(e);
      @(posedge clk_i);
      if (rst_i) begin
         plan_q.delete();
         m_count   = 0;
         m_timeout = 1'b0;
      end else if (plan_q.size() > 0) begin
         void'(plan_q.pop_front());
         m_count = 0;
      end else if (take_excp) begin
         plan_q  = {1, 2, 3};
         m_pc    = bus.excp_pc_i;
         m_cause = bus.excp_cause_i;
         m_count = 0;
      end else if (e.stall != 6'b000000) begin
         if (m_count < TIMEOUT) m_count++;
         if (m_count == TIMEOUT) m_timeout = 1'b1;
      end else begin
         m_count = 0;
      end
      #1;
   endtask

   task automatic clear_inputs();
      bus.stallreq_if_i  = 1'b0;
      bus.stallreq_id_i  = 1'b0;
      bus.stallreq_ex_i  = 1'b0;
      bus.stallreq_mem_i = 1'b0;
      bus.excp_req_i     = 1'b0;
      bus.mret_i         = 1'b0;
   endtask

   // Monitor: compare whatever the driver predicted for this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL time_limit: got no completion expected completion");
      $fatal(1, "[TB] time limit expired");
   end

   initial begin
      rst_i = 1'b1;
      clear_inputs();
      bus.excp_cause_i = 32'h0;
      bus.excp_pc_i    = 32'h0;
      bus.mtvec_i      = 32'h0;
      bus.mepc_i       = 32'h0;
      @(posedge clk_i);
      #1;

      // Reset state
      repeat (2) apply_stimulus();
      rst_i = 1'b0;
      apply_stimulus();

      // Stall priority
      bus.stallreq_ex_i = 1'b1;  apply_stimulus();
      bus.stallreq_mem_i = 1'b1; apply_stimulus();
      bus.stallreq_mem_i = 1'b0; bus.stallreq_id_i = 1'b1; apply_stimulus();
      clear_inputs(); bus.stallreq_if_i = 1'b1; apply_stimulus();
      clear_inputs(); apply_stimulus();

      // Basic trap entry
      bus.excp_req_i = 1'b1; bus.excp_pc_i = 32'h0000_0104;
      bus.excp_cause_i = 32'd2; bus.mtvec_i = 32'h0000_0201;
      apply_stimulus();
      bus.excp_req_i = 1'b0;
      repeat (4) apply_stimulus();

      // Exception and mret together; both held during the trap and ignored
      bus.mepc_i = 32'h0000_0080; bus.excp_pc_i = 32'h0000_0300;
      bus.excp_cause_i = 32'h8000_0007; bus.mtvec_i = 32'h0000_1000;
      bus.excp_req_i = 1'b1; bus.mret_i = 1'b1;
      repeat (3) apply_stimulus();
      clear_inputs();
      repeat (2) apply_stimulus();

      // mret, then mret blocked by a memory stall
      bus.mret_i = 1'b1; apply_stimulus();
      bus.stallreq_mem_i = 1'b1; repeat (3) apply_stimulus();
      bus.stallreq_mem_i = 1'b0; apply_stimulus();
      bus.mret_i = 1'b0; apply_stimulus();

      // Exception held off by a memory stall
      bus.excp_req_i = 1'b1; bus.stallreq_mem_i = 1'b1; bus.excp_pc_i = 32'h0000_0444;
      repeat (3) apply_stimulus();
      bus.stallreq_mem_i = 1'b0; apply_stimulus();
      bus.excp_req_i = 1'b0; repeat (4) apply_stimulus();

      // Watchdog: long fetch stall, sticky flag, cleared by reset
      bus.stallreq_if_i = 1'b1;
      repeat (TIMEOUT + 2) apply_stimulus();
      bus.stallreq_if_i = 1'b0;
      repeat (3) apply_stimulus();
      rst_i = 1'b1; apply_stimulus();
      rst_i = 1'b0; repeat (2) apply_stimulus();

      // Reset in the middle of a trap
      bus.excp_req_i = 1'b1; bus.excp_pc_i = 32'h0000_0555; bus.excp_cause_i = 32'd11;
      apply_stimulus();
      bus.excp_req_i = 1'b0; apply_stimulus();
      rst_i = 1'b1; apply_stimulus();
      rst_i = 1'b0; repeat (4) apply_stimulus();

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         rst_i              = ($urandom_range(0, 63) == 0);
         bus.stallreq_if_i  = ($urandom_range(0, 3) == 0);
         bus.stallreq_id_i  = ($urandom_range(0, 5) == 0);
         bus.stallreq_ex_i  = ($urandom_range(0, 5) == 0);
         bus.stallreq_mem_i = ($urandom_range(0, 4) == 0);
         bus.excp_req_i     = ($urandom_range(0, 7) == 0);
         bus.mret_i         = ($urandom_range(0, 7) == 0);
         bus.excp_pc_i      = $urandom;
         bus.excp_cause_i   = $urandom;
         bus.mtvec_i        = $urandom;
         bus.mepc_i         = $urandom;
         apply_stimulus();
      end
      rst_i = 1'b0;
      clear_inputs();
      repeat (2) apply_stimulus();

      @(negedge clk_i);
      check_field("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
